// File: rtl/router_fsm_if.sv
// Signal bundle between the router source/register side and the packet
// sequencing controller. The master drives packet and FIFO status; the slave
// (router_fsm) returns the register-block strobes and the FIFO select.
interface router_fsm_if #(
  parameter int NPORTS = 3
);

  // Source and register-block status seen by the controller
  logic              pkt_valid;
  logic [1:0]        data_in;
  logic              fifo_full;
  logic [NPORTS-1:0] fifo_empty;
  logic [NPORTS-1:0] soft_reset;
  logic              parity_done;
  logic              low_packet_valid;

  // Controller strobes and FIFO select
  logic              detect_addr;
  logic              lfd_state;
  logic              ld_state;
  logic              full_state;
  logic              laf_state;
  logic              rst_int_reg;
  logic              write_enb_reg;
  logic              busy;
  logic [1:0]        addr;

  modport master (
    output pkt_valid,
    output data_in,
    output fifo_full,
    output fifo_empty,
    output soft_reset,
    output parity_done,
    output low_packet_valid,
    input  detect_addr,
    input  lfd_state,
    input  ld_state,
    input  full_state,
    input  laf_state,
    input  rst_int_reg,
    input  write_enb_reg,
    input  busy,
    input  addr
  );

  modport slave (
    input  pkt_valid,
    input  data_in,
    input  fifo_full,
    input  fifo_empty,
    input  soft_reset,
    input  parity_done,
    input  low_packet_valid,
    output detect_addr,
    output lfd_state,
    output ld_state,
    output full_state,
    output laf_state,
    output rst_int_reg,
    output write_enb_reg,
    output busy,
    output addr
  );

endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the 1xN router input path.
// Decodes the header address, then walks the register block through the
// header, payload, FIFO-full stall, parity load and parity check phases.
// Moore machine: every output is a decode of the state and address flops.
module router_fsm #(
  parameter int NPORTS = 3
) (
  input  logic        clk,
  input  logic        reset,
  router_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q,  addr_d;

  logic header_ok;
  logic soft_reset_hit;

  // Header qualification and timeout detection for the FIFO currently selected
  always_comb begin
    header_ok      = bus.pkt_valid && (int'(bus.data_in) < NPORTS);
    soft_reset_hit = bus.soft_reset[addr_q];
  end

  // Next-state and address-latch logic; a timeout on the selected FIFO
  // abandons the packet from any state except the idle decode state
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if ((state_q != DECODE_ADDRESS) && soft_reset_hit) begin
      state_d = DECODE_ADDRESS;
    end else begin
      unique case (state_q)
        DECODE_ADDRESS: begin
          if (header_ok) begin
            addr_d  = bus.data_in;
            state_d = bus.fifo_empty[bus.data_in] ? LOAD_FIRST_DATA
                                                  : WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: begin
          state_d = LOAD_DATA;
        end
        LOAD_DATA: begin
          if (bus.fifo_full)
            state_d = FIFO_FULL_STATE;
          else if (!bus.pkt_valid)
            state_d = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!bus.fifo_full)
            state_d = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (bus.parity_done)
            state_d = DECODE_ADDRESS;
          else if (bus.low_packet_valid)
            state_d = LOAD_PARITY;
          else
            state_d = LOAD_DATA;
        end
        LOAD_PARITY: begin
          state_d = CHECK_PARITY_ERROR;
        end
        CHECK_PARITY_ERROR: begin
          state_d = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        end
        WAIT_TILL_EMPTY: begin
          if (bus.fifo_empty[addr_q])
            state_d = LOAD_FIRST_DATA;
        end
        default: begin
          state_d = DECODE_ADDRESS;
        end
      endcase
    end
  end

  // State and address registers with synchronous reset back to idle decode
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore output decode; the source may only advance in decode and payload
  always_comb begin
    bus.detect_addr   = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.full_state    = 1'b0;
    bus.laf_state     = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.busy          = 1'b1;
    bus.addr          = addr_q;
    unique case (state_q)
      DECODE_ADDRESS: begin
        bus.detect_addr = 1'b1;
        bus.busy        = 1'b0;
      end
      LOAD_FIRST_DATA: begin
        bus.lfd_state = 1'b1;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b0;
      end
      FIFO_FULL_STATE: begin
        bus.full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        bus.write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        bus.rst_int_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: begin
        bus.busy = 1'b1;
      end
      default: begin
        bus.busy = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_router_fsm.sv
// Directed testbench for router_fsm. Each expected output pattern below is
// the hand-derived Moore decode of one state, packed as
// {detect_addr, lfd, ld, full, laf, rst_int_reg, write_enb_reg, busy}.
module tb_router_fsm;

  localparam int NPORTS = 3;

  localparam logic [7:0] S_DA  = 8'b1000_0000;
  localparam logic [7:0] S_LFD = 8'b0100_0001;
  localparam logic [7:0] S_LD  = 8'b0010_0010;
  localparam logic [7:0] S_FFS = 8'b0001_0001;
  localparam logic [7:0] S_LAF = 8'b0000_1011;
  localparam logic [7:0] S_LP  = 8'b0000_0011;
  localparam logic [7:0] S_CPE = 8'b0000_0101;
  localparam logic [7:0] S_WTE = 8'b0000_0001;

  logic clk;
  logic reset;
  int   compareCount;
  int   mismatchCount;
  int   weCount;
  int   busyCount;

  router_fsm_if #(.NPORTS(NPORTS)) bus_if ();

  router_fsm #(.NPORTS(NPORTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  logic [7:0] outs;
  assign outs = {bus_if.detect_addr, bus_if.lfd_state, bus_if.ld_state,
                 bus_if.full_state, bus_if.laf_state, bus_if.rst_int_reg,
                 bus_if.write_enb_reg, bus_if.busy};

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it in, and settle just after the edge
  task automatic applyStimulus(input logic pv, input logic [1:0] din,
                               input logic full, input logic [2:0] empty,
                               input logic [2:0] srst, input logic pdone,
                               input logic lpv);
    bus_if.pkt_valid        = pv;
    bus_if.data_in          = din;
    bus_if.fifo_full        = full;
    bus_if.fifo_empty       = empty;
    bus_if.soft_reset       = srst;
    bus_if.parity_done      = pdone;
    bus_if.low_packet_valid = lpv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [7:0] expOuts,
                            input logic [1:0] expAddr);
    checkOutput({tag, " outs"}, {24'd0, outs}, {24'd0, expOuts});
    checkOutput({tag, " addr"}, {30'd0, bus_if.addr}, {30'd0, expAddr});
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;

    // Reset held for two edges
    reset = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("reset", S_DA, 2'd0);
    checkOutput("reset busy", {31'd0, bus_if.busy}, 32'd0);
    checkOutput("reset we", {31'd0, bus_if.write_enb_reg}, 32'd0);
    reset = 1'b0;

    // Header 8'h21 to FIFO 1, eight payload bytes, then parity
    applyStimulus(1'b1, 2'b01, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t2 header", S_LFD, 2'd1);
    weCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 2'(i), 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
      checkState("t2 payload", S_LD, 2'd1);
      weCount += int'(bus_if.write_enb_reg);
    end
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t2 parity", S_LP, 2'd1);
    weCount += int'(bus_if.write_enb_reg);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t2 check", S_CPE, 2'd1);
    weCount += int'(bus_if.write_enb_reg);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t2 idle", S_DA, 2'd1);
    checkOutput("t2 we cycles", weCount, 32'd9);

    // Header to FIFO 2 while it is not empty: wait five cycles
    applyStimulus(1'b1, 2'd2, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
    checkState("t3 wait", S_WTE, 2'd2);
    busyCount = int'(bus_if.busy);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 1'b0, 3'b011, 3'b000, 1'b0, 1'b0);
      checkState("t3 wait hold", S_WTE, 2'd2);
      busyCount += int'(bus_if.busy);
    end
    checkOutput("t3 busy cycles", busyCount, 32'd5);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t3 released", S_LFD, 2'd2);

    // Payload bytes 1 and 2, then FIFO full for four edges at byte 3
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 byte1", S_LD, 2'd2);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 byte2", S_LD, 2'd2);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
      checkState("t4 full", S_FFS, 2'd2);
    end
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 after full", S_LAF, 2'd2);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 resume", S_LD, 2'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 parity", S_LP, 2'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 check", S_CPE, 2'd2);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4 idle", S_DA, 2'd2);

    // FIFO 0: low_packet_valid after full, full again at parity check,
    // then parity_done closes the packet
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b header", S_LFD, 2'd0);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b byte1", S_LD, 2'd0);
    applyStimulus(1'b1, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b full", S_FFS, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b laf", S_LAF, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b1);
    checkState("t4b low pkt", S_LP, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b check", S_CPE, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b cpe full", S_FFS, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t4b laf2", S_LAF, 2'd0);
    applyStimulus(1'b0, 2'd0, 1'b0, 3'b111, 3'b000, 1'b1, 1'b0);
    checkState("t4b parity done", S_DA, 2'd0);

    // Soft reset: non-addressed FIFO ignored, addressed FIFO aborts
    applyStimulus(1'b1, 2'd1, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t5 header", S_LFD, 2'd1);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t5 byte1", S_LD, 2'd1);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b001, 1'b0, 1'b0);
    checkState("t5 other srst", S_LD, 2'd1);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b010, 1'b0, 1'b0);
    checkState("t5 own srst", S_DA, 2'd1);

    // Out-of-range header ignored; reset mid-payload returns to idle
    applyStimulus(1'b1, 2'b11, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t6 bad addr", S_DA, 2'd1);
    applyStimulus(1'b1, 2'd2, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t6 header", S_LFD, 2'd2);
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t6 byte1", S_LD, 2'd2);
    reset = 1'b1;
    applyStimulus(1'b1, 2'd0, 1'b0, 3'b111, 3'b000, 1'b0, 1'b0);
    checkState("t6 reset", S_DA, 2'd0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
